// File: rtl/alien_plot_sink.sv
// alien_plot_sink
// Sits between the sprite sequencer and the VGA adapter. Each pixel write is
// offset by the latched sprite origin and then queued in a 4-entry FIFO.
// Queued pixels are presented to the adapter in arrival order, with a
// registered handshake.
// Optional feature: if `ALIEN_PLOT_CLIP_EN is defined, any write whose column
// falls off the 160-wide screen is discarded.
module alien_plot_sink (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_base,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [2:0] add_x,
  input  logic [2:0] colour,
  input  logic       write_en,
  input  logic       plot_ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       overflow,
  output logic [7:0] pixel_count
);

  typedef enum logic {EMPTY, HOLD} stateT;

  stateT       r_state;
  stateT       w_stateNext;
  logic [7:0]  r_orgX;
  logic [6:0]  r_orgY;
  logic [17:0] r_mem [4];
  logic [1:0]  r_wrPtr;
  logic [1:0]  r_rdPtr;
  logic [2:0]  r_count;
  logic        r_overflow;
  logic [7:0]  r_pixelCount;

  logic [7:0]  w_colX;
  logic        w_clip;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [17:0] w_head;

`ifdef ALIEN_PLOT_CLIP_EN
  logic [8:0]  w_sum;
  assign w_sum  = {1'b0, r_orgX} + {6'b0, add_x};
  assign w_colX = w_sum[7:0];
  assign w_clip = write_en && (w_sum >= 9'd160);
`else
  assign w_colX = r_orgX + {5'b0, add_x};
  assign w_clip = 1'b0;
`endif

  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_full = (r_count == 3'd4);
  assign w_pop  = plot & plot_ready;
  assign w_push = write_en & ~w_clip & (~w_full | w_pop);
  assign w_drop = write_en & ~w_clip & w_full & ~w_pop;
  assign w_head = r_mem[r_rdPtr];

  // Head outputs are forced to zero whenever nothing is being presented.
  assign plot        = (r_state == HOLD);
  assign x           = plot ? w_head[17:10] : 8'd0;
  assign y           = plot ? w_head[9:3]   : 7'd0;
  assign colour_out  = plot ? w_head[2:0]   : 3'd0;
  assign overflow    = r_overflow;
  assign pixel_count = r_pixelCount;

  // Latch the sprite origin. An entry formed in the same cycle still uses the old origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_orgX <= 8'd0;
      r_orgY <= 7'd0;
    end else if (load_base) begin
      r_orgX <= base_x;
      r_orgY <= base_y;
    end
  end

  // FIFO storage. It has no reset because stale slots are never presented.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {w_colX, r_orgY, colour};
    end
  end

  // Update the pointers and occupancy. The 2-bit pointers wrap naturally from 3 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= 2'd0;
      r_rdPtr <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 2'd1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag, plus a saturating counter of delivered pixels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_pixelCount <= 8'd0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop && (r_pixelCount != 8'd255)) r_pixelCount <= r_pixelCount + 8'd1;
    end
  end

  // Output-side state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_stateNext;
  end

  // HOLD while the FIFO has data. Leave only when the last entry pops with no refill.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      EMPTY: if (w_push) w_stateNext = HOLD;
      HOLD:  if (w_pop && (r_count == 3'd1) && !w_push) w_stateNext = EMPTY;
      default: w_stateNext = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_alien_plot_sink.sv
// Directed testbench for alien_plot_sink. Every expected value is worked out
// by hand from the intended behaviour.
module tb_alien_plot_sink;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_base;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] add_x;
  logic [2:0] colour;
  logic       write_en;
  logic       plot_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_out;
  logic       plot;
  logic       overflow;
  logic [7:0] pixel_count;

  int checks = 0;
  int errors = 0;
  int expPc  = 0;

  alien_plot_sink dut (
    .clk(clk), .reset_n(reset_n), .load_base(load_base),
    .base_x(base_x), .base_y(base_y), .add_x(add_x), .colour(colour),
    .write_en(write_en), .plot_ready(plot_ready),
    .x(x), .y(y), .colour_out(colour_out), .plot(plot),
    .overflow(overflow), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit so the new state can be sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    load_base = 0; base_x = 0; base_y = 0; add_x = 0;
    colour = 0; write_en = 0; plot_ready = 0;
  endtask

  task automatic pulseReset();
    reset_n = 0;
    #2;
    reset_n = 1;
    tick();
    expPc = 0;
  endtask

  task automatic loadOrigin(input logic [7:0] bx, input logic [6:0] by);
    load_base = 1; base_x = bx; base_y = by;
    tick();
    load_base = 0;
  endtask

  task automatic writePix(input logic [2:0] ax, input logic [2:0] col, input logic rdy);
    write_en = 1; add_x = ax; colour = col; plot_ready = rdy;
    tick();
    write_en = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset_n = 0;
    #2;
    checks++;
    if ({x, y, colour_out, plot, overflow, pixel_count} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got x=%0d y=%0d c=%0d plot=%0b ovf=%0b pc=%0d want all 0",
               x, y, colour_out, plot, overflow, pixel_count);
    end
    reset_n = 1;
    tick();
    checks++;
    if (plot !== 1'b0 || pixel_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL after_release got plot=%0b pc=%0d want 0 0", plot, pixel_count);
    end
  endtask

  task automatic test_single_pixel();
    loadOrigin(8'd10, 7'd20);
    checks++;
    if (plot !== 1'b0) begin
      errors++; $display("[TB] FAIL single_pre got plot=%0b want 0", plot);
    end
    writePix(3'd3, 3'd5, 1'b1);
    checks++;
    if (plot !== 1'b1 || x !== 8'd13 || y !== 7'd20 || colour_out !== 3'd5) begin
      errors++;
      $display("[TB] FAIL single_head got plot=%0b x=%0d y=%0d c=%0d want 1 13 20 5", plot, x, y, colour_out);
    end
    tick();
    expPc++;
    checks++;
    if (plot !== 1'b0 || pixel_count !== expPc[7:0] || x !== 8'd0) begin
      errors++;
      $display("[TB] FAIL single_after got plot=%0b pc=%0d x=%0d want 0 %0d 0", plot, pixel_count, x, expPc);
    end
  endtask

  task automatic test_burst();
    logic [2:0] cols [5];
    cols = '{3'd0, 3'd5, 3'd5, 3'd5, 3'd0};
    loadOrigin(8'd30, 7'd40);
    for (int i = 0; i < 5; i++) writePix(i[2:0], cols[i], 1'b0);
    checks++;
    if (overflow !== 1'b1 || plot !== 1'b1 || x !== 8'd30) begin
      errors++;
      $display("[TB] FAIL burst_overflow got ovf=%0b plot=%0b x=%0d want 1 1 30", overflow, plot, x);
    end
    tick();
    checks++;
    if (x !== 8'd30 || y !== 7'd40 || colour_out !== 3'd0 || plot !== 1'b1) begin
      errors++;
      $display("[TB] FAIL burst_hold got x=%0d y=%0d c=%0d plot=%0b want 30 40 0 1", x, y, colour_out, plot);
    end
    plot_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (plot !== 1'b1 || x !== 8'(30 + i) || y !== 7'd40 || colour_out !== cols[i]) begin
        errors++;
        $display("[TB] FAIL burst_pix%0d got plot=%0b x=%0d y=%0d c=%0d want 1 %0d 40 %0d",
                 i, plot, x, y, colour_out, 30 + i, cols[i]);
      end
      tick();
      expPc++;
    end
    checks++;
    if (plot !== 1'b0 || pixel_count !== expPc[7:0] || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL burst_end got plot=%0b pc=%0d ovf=%0b want 0 %0d 1", plot, pixel_count, overflow, expPc);
    end
    plot_ready = 0;
  endtask

  task automatic test_full_push_pop();
    int expX [4];
    expX = '{1, 2, 3, 7};
    pulseReset();
    loadOrigin(8'd0, 7'd1);
    for (int i = 0; i < 4; i++) writePix(i[2:0], 3'(i + 1), 1'b0);
    writePix(3'd7, 3'd7, 1'b1);
    expPc++;
    checks++;
    if (overflow !== 1'b0 || plot !== 1'b1 || x !== 8'd1 || colour_out !== 3'd2) begin
      errors++;
      $display("[TB] FAIL full_pushpop got ovf=%0b plot=%0b x=%0d c=%0d want 0 1 1 2", overflow, plot, x, colour_out);
    end
    plot_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (plot !== 1'b1 || x !== expX[i][7:0]) begin
        errors++;
        $display("[TB] FAIL full_order%0d got plot=%0b x=%0d want 1 %0d", i, plot, x, expX[i]);
      end
      tick();
      expPc++;
    end
    checks++;
    if (plot !== 1'b0 || pixel_count !== expPc[7:0] || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_end got plot=%0b pc=%0d ovf=%0b want 0 %0d 0", plot, pixel_count, overflow, expPc);
    end
    plot_ready = 0;
  endtask

  task automatic test_origin_race();
    loadOrigin(8'd10, 7'd20);
    load_base = 1; base_x = 8'd50; base_y = 7'd7;
    writePix(3'd1, 3'd2, 1'b0);
    load_base = 0;
    writePix(3'd1, 3'd3, 1'b0);
    checks++;
    if (x !== 8'd11 || y !== 7'd20 || colour_out !== 3'd2) begin
      errors++;
      $display("[TB] FAIL race_old got x=%0d y=%0d c=%0d want 11 20 2", x, y, colour_out);
    end
    plot_ready = 1;
    tick();
    expPc++;
    checks++;
    if (x !== 8'd51 || y !== 7'd7 || colour_out !== 3'd3) begin
      errors++;
      $display("[TB] FAIL race_new got x=%0d y=%0d c=%0d want 51 7 3", x, y, colour_out);
    end
    tick();
    expPc++;
    plot_ready = 0;
  endtask

  task automatic test_clip();
    loadOrigin(8'd158, 7'd0);
    writePix(3'd4, 3'd6, 1'b0);
    loadOrigin(8'd254, 7'd0);
    writePix(3'd3, 3'd1, 1'b0);
`ifdef ALIEN_PLOT_CLIP_EN
    checks++;
    if (plot !== 1'b0 || pixel_count !== expPc[7:0] || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clip_drop got plot=%0b pc=%0d ovf=%0b want 0 %0d 0", plot, pixel_count, overflow, expPc);
    end
`else
    checks++;
    if (plot !== 1'b1 || x !== 8'd162 || colour_out !== 3'd6) begin
      errors++;
      $display("[TB] FAIL clip_wide got plot=%0b x=%0d c=%0d want 1 162 6", plot, x, colour_out);
    end
    plot_ready = 1;
    tick();
    expPc++;
    checks++;
    if (plot !== 1'b1 || x !== 8'd1 || colour_out !== 3'd1) begin
      errors++;
      $display("[TB] FAIL clip_wrap got plot=%0b x=%0d c=%0d want 1 1 1", plot, x, colour_out);
    end
    tick();
    expPc++;
    checks++;
    if (plot !== 1'b0 || pixel_count !== expPc[7:0]) begin
      errors++;
      $display("[TB] FAIL clip_count got plot=%0b pc=%0d want 0 %0d", plot, pixel_count, expPc);
    end
    plot_ready = 0;
`endif
  endtask

  task automatic test_async_reset();
    loadOrigin(8'd5, 7'd5);
    for (int i = 0; i < 3; i++) writePix(i[2:0], 3'd4, 1'b0);
    checks++;
    if (plot !== 1'b1 || pixel_count === 8'd0) begin
      errors++;
      $display("[TB] FAIL areset_pre got plot=%0b pc=%0d want 1 nonzero", plot, pixel_count);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (plot !== 1'b0 || pixel_count !== 8'd0 || x !== 8'd0 || y !== 7'd0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_now got plot=%0b pc=%0d x=%0d y=%0d ovf=%0b want 0 0 0 0 0",
               plot, pixel_count, x, y, overflow);
    end
    #2;
    reset_n = 1;
    plot_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (plot !== 1'b0 || pixel_count !== 8'd0) begin
        errors++;
        $display("[TB] FAIL areset_post%0d got plot=%0b pc=%0d want 0 0", i, plot, pixel_count);
      end
    end
    plot_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_burst();
    test_full_push_pop();
    test_origin_race();
    test_clip();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
